// File: rtl/dmem_responder.sv
// dmem_responder: data-memory target with valid/ready request/response handshakes and programmable wait states
module dmem_responder #(
   parameter int unsigned DEPTH     = 1024,
   parameter int unsigned LATENCY   = 2,
   parameter logic [63:0] BASE_ADDR = 64'h0
) (
   input  logic        CLK,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_rdata,
   output logic        rsp_err
);
   localparam int unsigned AW = $clog2(DEPTH);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t      r_state;
   logic [3:0]  r_cnt;
   logic        r_write;
   logic [63:0] r_addr;
   logic [63:0] r_wdata;
   logic        r_req_ready;
   logic        r_rsp_valid;
   logic        r_rsp_err;
   logic [63:0] r_rsp_rdata;
   logic [63:0] r_mem [DEPTH];
   logic [60:0] w_word;
   logic [AW-1:0] w_idx;
   logic        w_err;
   logic        w_commit;
   // word offset from the base; the range test below runs on the full-width value so nothing wraps
   assign w_word   = 61'((r_addr - BASE_ADDR) >> 3);
   assign w_idx    = w_word[AW-1:0];
   assign w_err    = (r_addr[2:0] != 3'd0) || (r_addr < BASE_ADDR) || (w_word >= 61'(DEPTH));
   assign w_commit = (r_state == WAIT) && (r_cnt == 4'd0);
   assign req_ready = r_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;
   // array write at the commit edge; reset in the same cycle suppresses it, contents are never cleared
   always_ff @(posedge CLK) begin
      if (!reset && w_commit && r_write && !w_err) r_mem[w_idx] <= r_wdata;
   end
   // transaction FSM: capture at accept, count wait states, commit, then hold the response until taken
   always_ff @(posedge CLK) begin
      if (reset) begin
         r_state     <= IDLE;
         r_cnt       <= 4'd0;
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= 64'h0;
         r_rsp_err   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (req_valid) begin
               r_write     <= req_write;
               r_addr      <= req_addr;
               r_wdata     <= req_wdata;
               r_cnt       <= 4'(LATENCY);
               r_req_ready <= 1'b0;
               r_state     <= WAIT;
            end
            WAIT: if (r_cnt == 4'd0) begin
               r_rsp_valid <= 1'b1;
               r_rsp_err   <= w_err;
               r_rsp_rdata <= (r_write || w_err) ? 64'h0 : r_mem[w_idx];
               r_state     <= RESP;
            end else begin
               r_cnt <= r_cnt - 4'd1;
            end
            RESP: if (rsp_ready) begin
               r_rsp_valid <= 1'b0;
               r_rsp_rdata <= 64'h0;
               r_rsp_err   <= 1'b0;
               r_req_ready <= 1'b1;
               r_state     <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed bench over three builds (default, zero latency, offset base with small depth)
module tb_dmem_responder;
   logic CLK = 1'b0;
   logic reset;
   logic [2:0] rv, rw, rsr, rrdy, rspv, rerr;
   logic [2:0][63:0] ra, rwd, rdat;
   int tests = 0;
   int fails = 0;
   int lat;
   logic [63:0] rd;
   logic e;

   always #5 CLK = ~CLK;

   dmem_responder #(.DEPTH(1024), .LATENCY(2), .BASE_ADDR(64'h0)) u0 (
      .CLK(CLK), .reset(reset), .req_valid(rv[0]), .req_ready(rrdy[0]), .req_write(rw[0]),
      .req_addr(ra[0]), .req_wdata(rwd[0]), .rsp_valid(rspv[0]), .rsp_ready(rsr[0]),
      .rsp_rdata(rdat[0]), .rsp_err(rerr[0]));
   dmem_responder #(.DEPTH(1024), .LATENCY(0), .BASE_ADDR(64'h0)) u1 (
      .CLK(CLK), .reset(reset), .req_valid(rv[1]), .req_ready(rrdy[1]), .req_write(rw[1]),
      .req_addr(ra[1]), .req_wdata(rwd[1]), .rsp_valid(rspv[1]), .rsp_ready(rsr[1]),
      .rsp_rdata(rdat[1]), .rsp_err(rerr[1]));
   dmem_responder #(.DEPTH(16), .LATENCY(1), .BASE_ADDR(64'h1000)) u2 (
      .CLK(CLK), .reset(reset), .req_valid(rv[2]), .req_ready(rrdy[2]), .req_write(rw[2]),
      .req_addr(ra[2]), .req_wdata(rwd[2]), .rsp_valid(rspv[2]), .rsp_ready(rsr[2]),
      .rsp_rdata(rdat[2]), .rsp_err(rerr[2]));

   // Issue one request on instance k (called at a negedge); lat = negedges from accept until rsp_valid.
   // Request fields are scrambled right after the accept edge. Consumes the response if rsp_ready is high.
   task automatic xact(input int k, input logic w, input logic [63:0] a, input logic [63:0] d,
                       output int l, output logic [63:0] r, output logic er);
      int n;
      rv[k] = 1'b1; rw[k] = w; ra[k] = a; rwd[k] = d;
      n = 0;
      while (!rrdy[k] && n < 50) begin @(negedge CLK); n++; end
      @(negedge CLK);
      rv[k] = 1'b0; rw[k] = ~w; ra[k] = ~a; rwd[k] = ~d;
      l = 0;
      while (!rspv[k] && l < 50) begin @(negedge CLK); l++; end
      r = rdat[k]; er = rerr[k];
      if (rsr[k]) @(negedge CLK);
   endtask

   task automatic test_reset();
      reset = 1'b1; rv = '0; rw = '0; rsr = 3'b111; ra = '0; rwd = '0;
      repeat (3) @(negedge CLK);
      reset = 1'b0;
      @(negedge CLK);
      tests++; if (rrdy !== 3'b111) begin fails++; $display("FAIL rst_ready: got %b need 111", rrdy); end
      tests++; if (rspv !== 3'b000 || rerr !== 3'b000) begin fails++; $display("FAIL rst_valid_err: got %b/%b need 000/000", rspv, rerr); end
      tests++; if (rdat[0] !== 64'h0 || rdat[1] !== 64'h0 || rdat[2] !== 64'h0) begin fails++; $display("FAIL rst_rdata: got %h %h %h need 0", rdat[0], rdat[1], rdat[2]); end
   endtask

   task automatic test_store_load();
      xact(0, 1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D, lat, rd, e);
      tests++; if (lat !== 3 || e !== 1'b0 || rd !== 64'h0) begin fails++; $display("FAIL store10: lat=%0d err=%b rdata=%h need 3/0/0", lat, e, rd); end
      xact(0, 1'b0, 64'h10, 64'h0, lat, rd, e);
      tests++; if (lat !== 3 || e !== 1'b0 || rd !== 64'hDEADBEEF_CAFEF00D) begin fails++; $display("FAIL load10: lat=%0d err=%b rdata=%h need 3/0/deadbeefcafef00d", lat, e, rd); end
   endtask

   task automatic test_errors();
      xact(0, 1'b1, 64'h1FF8, 64'hA5A5_0000_1FF8_0001, lat, rd, e);
      tests++; if (e !== 1'b0 || rd !== 64'h0) begin fails++; $display("FAIL store1ff8: err=%b rdata=%h need 0/0", e, rd); end
      xact(0, 1'b0, 64'h13, 64'h0, lat, rd, e);
      tests++; if (e !== 1'b1 || rd !== 64'h0) begin fails++; $display("FAIL misalign: err=%b rdata=%h need 1/0", e, rd); end
      xact(0, 1'b1, 64'h2000, 64'h1234_5678_9ABC_DEF0, lat, rd, e);
      tests++; if (e !== 1'b1 || rd !== 64'h0 || lat !== 3) begin fails++; $display("FAIL range2000: err=%b rdata=%h lat=%0d need 1/0/3", e, rd, lat); end
      xact(0, 1'b0, 64'h1FF8, 64'h0, lat, rd, e);
      tests++; if (e !== 1'b0 || rd !== 64'hA5A5_0000_1FF8_0001) begin fails++; $display("FAIL load1ff8: err=%b rdata=%h need 0/a5a500001ff80001", e, rd); end
      xact(0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, lat, rd, e);
      tests++; if (e !== 1'b1 || rd !== 64'h0) begin fails++; $display("FAIL toprange: err=%b rdata=%h need 1/0", e, rd); end
   endtask

   task automatic test_backpressure();
      logic ok;
      xact(0, 1'b1, 64'h08, 64'h0808_0808_0808_0808, lat, rd, e);
      rsr[0] = 1'b0;
      xact(0, 1'b0, 64'h08, 64'h0, lat, rd, e);
      tests++; if (rspv[0] !== 1'b1 || rd !== 64'h0808_0808_0808_0808 || e !== 1'b0) begin fails++; $display("FAIL bp_first: valid=%b rdata=%h err=%b need 1/0808080808080808/0", rspv[0], rd, e); end
      ok = 1'b1;
      repeat (10) begin
         @(negedge CLK);
         if (rspv[0] !== 1'b1 || rdat[0] !== 64'h0808_0808_0808_0808 || rerr[0] !== 1'b0 || rrdy[0] !== 1'b0) ok = 1'b0;
      end
      tests++; if (!ok) begin fails++; $display("FAIL bp_hold: valid=%b rdata=%h err=%b ready=%b need 1/0808080808080808/0/0", rspv[0], rdat[0], rerr[0], rrdy[0]); end
      rsr[0] = 1'b1;
      @(negedge CLK);
      tests++; if (rspv[0] !== 1'b0 || rrdy[0] !== 1'b1 || rdat[0] !== 64'h0) begin fails++; $display("FAIL bp_release: valid=%b ready=%b rdata=%h need 0/1/0", rspv[0], rrdy[0], rdat[0]); end
      ok = 1'b1;
      repeat (3) begin @(negedge CLK); if (rspv[0] !== 1'b0) ok = 1'b0; end
      tests++; if (!ok) begin fails++; $display("FAIL bp_single: valid=%b need 0", rspv[0]); end
   endtask

   task automatic test_reset_mid();
      logic ok;
      xact(0, 1'b1, 64'h18, 64'h5555, lat, rd, e);
      rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 64'h18; rwd[0] = 64'h1111;
      @(negedge CLK);
      rv[0] = 1'b0; reset = 1'b1;
      @(negedge CLK);
      reset = 1'b0;
      tests++; if (rrdy[0] !== 1'b1 || rspv[0] !== 1'b0 || rerr[0] !== 1'b0 || rdat[0] !== 64'h0) begin fails++; $display("FAIL rst_wait: ready=%b valid=%b err=%b rdata=%h need 1/0/0/0", rrdy[0], rspv[0], rerr[0], rdat[0]); end
      ok = 1'b1;
      repeat (5) begin @(negedge CLK); if (rspv[0] !== 1'b0) ok = 1'b0; end
      tests++; if (!ok) begin fails++; $display("FAIL rst_wait_quiet: valid=%b need 0", rspv[0]); end
      xact(0, 1'b0, 64'h18, 64'h0, lat, rd, e);
      tests++; if (rd !== 64'h5555 || e !== 1'b0) begin fails++; $display("FAIL rst_wait_data: rdata=%h err=%b need 5555/0", rd, e); end
      rsr[0] = 1'b0;
      xact(0, 1'b1, 64'h20, 64'h77, lat, rd, e);
      reset = 1'b1;
      @(negedge CLK);
      reset = 1'b0; rsr[0] = 1'b1;
      tests++; if (rspv[0] !== 1'b0 || rrdy[0] !== 1'b1) begin fails++; $display("FAIL rst_resp: valid=%b ready=%b need 0/1", rspv[0], rrdy[0]); end
      xact(0, 1'b0, 64'h20, 64'h0, lat, rd, e);
      tests++; if (rd !== 64'h77 || e !== 1'b0) begin fails++; $display("FAIL rst_resp_data: rdata=%h err=%b need 77/0", rd, e); end
   endtask

   task automatic test_back_to_back();
      logic [63:0] exp;
      int n;
      xact(1, 1'b1, 64'h40, 64'h4040_4040, lat, rd, e);
      tests++; if (lat !== 1 || e !== 1'b0) begin fails++; $display("FAIL l0_store: lat=%0d err=%b need 1/0", lat, e); end
      xact(1, 1'b1, 64'h48, 64'h4848_4848, lat, rd, e);
      rv[1] = 1'b1; rw[1] = 1'b0; ra[1] = 64'h40;
      for (int i = 0; i < 4; i++) begin
         n = 0;
         while (!rrdy[1] && n < 10) begin @(negedge CLK); n++; end
         exp = (ra[1] == 64'h40) ? 64'h4040_4040 : 64'h4848_4848;
         @(negedge CLK);
         tests++; if (rrdy[1] !== 1'b0 || rspv[1] !== 1'b0) begin fails++; $display("FAIL b2b_busy%0d: ready=%b valid=%b need 0/0", i, rrdy[1], rspv[1]); end
         ra[1] = (ra[1] == 64'h40) ? 64'h48 : 64'h40;
         @(negedge CLK);
         tests++; if (rspv[1] !== 1'b1 || rdat[1] !== exp || rerr[1] !== 1'b0) begin fails++; $display("FAIL b2b_rsp%0d: valid=%b rdata=%h err=%b need 1/%h/0", i, rspv[1], rdat[1], rerr[1], exp); end
         if (i == 3) rv[1] = 1'b0;
      end
      @(negedge CLK);
   endtask

   task automatic test_base_addr();
      xact(2, 1'b0, 64'h0FF8, 64'h0, lat, rd, e);
      tests++; if (e !== 1'b1 || rd !== 64'h0) begin fails++; $display("FAIL base_below: err=%b rdata=%h need 1/0", e, rd); end
      xact(2, 1'b1, 64'h1000, 64'hB0B0_1000, lat, rd, e);
      tests++; if (lat !== 2 || e !== 1'b0) begin fails++; $display("FAIL base_store: lat=%0d err=%b need 2/0", lat, e); end
      xact(2, 1'b0, 64'h1000, 64'h0, lat, rd, e);
      tests++; if (rd !== 64'hB0B0_1000 || e !== 1'b0) begin fails++; $display("FAIL base_load: rdata=%h err=%b need b0b01000/0", rd, e); end
      xact(2, 1'b1, 64'h1078, 64'h7878, lat, rd, e);
      tests++; if (e !== 1'b0) begin fails++; $display("FAIL base_last: err=%b need 0", e); end
      xact(2, 1'b1, 64'h1080, 64'h8080, lat, rd, e);
      tests++; if (e !== 1'b1 || rd !== 64'h0) begin fails++; $display("FAIL base_over: err=%b rdata=%h need 1/0", e, rd); end
      xact(2, 1'b0, 64'h1078, 64'h0, lat, rd, e);
      tests++; if (rd !== 64'h7878 || e !== 1'b0) begin fails++; $display("FAIL base_last_load: rdata=%h err=%b need 7878/0", rd, e); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_store_load();
      test_errors();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      test_base_addr();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
